// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low gfedcba) used by the capture block and
// the display drivers, plus the digit-select helper.
package seg7_pkg;

    localparam int N7 = 7;
    localparam int N4 = 4;

    localparam logic [N7-1:0] BLANK = 7'h7F;

    localparam logic [N7-1:0] HEX_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {selected, index}: selected only when exactly one enable is low.
    function automatic logic [2:0] select_digit(input logic [N4-1:0] an);
        logic [2:0] zeros;
        logic [1:0] idx;
        zeros = '0;
        idx   = '0;
        for (int i = 0; i < N4; i++) begin
            if (!an[i]) begin
                zeros = zeros + 3'd1;
                idx   = 2'(i);
            end
        end
        return {(zeros == 3'd1), idx};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup from an active-low segment pattern to its hex value,
// flagging whether it is a hex digit or the blank pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [N7-1:0] pattern,
    output logic [3:0]    value,
    output logic          is_hex,
    output logic          is_blank
);

    always_comb begin
        value    = '0;
        is_hex   = 1'b0;
        is_blank = (pattern == BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == HEX_PATTERNS[i]) begin
                value  = 4'(i);
                is_hex = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 4-digit 7-segment display and recovers each digit's value.
// Build option SEG7_CAPTURE_RAW_EN adds the 'raw' port with each digit's last pattern.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int TIMEOUT       = 100_000_000
) (
    input  logic              clk,
    input  logic              btnU,
    input  logic [N7-1:0]     seg,
    input  logic [N4-1:0]     an,
    output logic [4*N4-1:0]   hex,
    output logic [N4-1:0]     valid,
    output logic [N4-1:0]     err,
    output logic              frame
`ifdef SEG7_CAPTURE_RAW_EN
    ,
    output logic [N7*N4-1:0]  raw
`endif
);

    localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [TCW-1:0] TIMEOUT_LIM = TCW'(TIMEOUT);

    logic [N7-1:0]    seg_s1, seg_s2;
    logic [N4-1:0]    an_s1, an_s2;
    logic [N4+N7-1:0] sample, prev_sample;
    logic [SCW-1:0]   stable_cnt;
    logic             captured;
    logic             selected;
    logic             stable;
    logic             capture;
    logic [1:0]       digit;
    logic [3:0]       dec_value;
    logic             dec_is_hex;
    logic             dec_is_blank;

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            an_s1  <= an;
            an_s2  <= an_s1;
        end
    end

    assign sample            = {an_s2, seg_s2};
    assign stable            = (sample == prev_sample);
    assign {selected, digit} = select_digit(an_s2);
    assign capture           = selected && stable && (stable_cnt == STABLE_LAST) && !captured;

    // The counter saturates at its last value; the captured flag stops a long
    // dwell from re-capturing until the sample changes or the digit is deselected.
    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            prev_sample <= '0;
            stable_cnt  <= '0;
            captured    <= 1'b0;
        end else begin
            prev_sample <= sample;
            if (!selected || !stable) begin
                stable_cnt <= '0;
                captured   <= 1'b0;
            end else begin
                if (stable_cnt != STABLE_LAST) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                if (capture) begin
                    captured <= 1'b1;
                end
            end
        end
    end

    seg7_decode u_decode (
        .pattern  (seg_s2),
        .value    (dec_value),
        .is_hex   (dec_is_hex),
        .is_blank (dec_is_blank)
    );

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            frame <= 1'b0;
        end else begin
            frame <= capture && (digit == 2'd3);
        end
    end

    for (genvar k = 0; k < N4; k++) begin : g_digit
        logic           hit;
        logic [TCW-1:0] age;
        logic [TCW-1:0] age_next;
        logic [3:0]     nibble;
        logic           valid_q;
        logic           err_q;

        assign hit      = capture && (digit == 2'(k));
        assign age_next = (age == TIMEOUT_LIM) ? age : age + 1'b1;

        // A capture beats an expiry landing on the same edge and restarts the age.
        always_ff @(posedge clk or posedge btnU) begin
            if (btnU) begin
                age     <= '0;
                nibble  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (hit) begin
                age <= '0;
                if (dec_is_hex) begin
                    nibble  <= dec_value;
                    valid_q <= 1'b1;
                    err_q   <= 1'b0;
                end else begin
                    valid_q <= 1'b0;
                    err_q   <= !dec_is_blank;
                end
            end else begin
                age <= age_next;
                if (age_next == TIMEOUT_LIM) begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            end
        end

        assign hex[4*k +: 4] = nibble;
        assign valid[k]      = valid_q;
        assign err[k]        = err_q;

`ifdef SEG7_CAPTURE_RAW_EN
        logic [N7-1:0] raw_q;

        always_ff @(posedge clk or posedge btnU) begin
            if (btnU) begin
                raw_q <= BLANK;
            end else if (hit) begin
                raw_q <= seg_s2;
            end
        end

        assign raw[N7*k +: N7] = raw_q;
`endif
    end

endmodule
